// File: rtl/instr_register_param.sv
// Parametrised instruction register: {opcode, a, b, result} per entry, DIV/MOD via restoring divider.
// Optional macro INSTR_REG_PARITY_EN adds per-entry even parity, par_inject input and rd_par_err output.
package instr_register_pkg;
  typedef enum logic [2:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
endpackage

module instr_register_param
  import instr_register_pkg::*;
#(
  parameter  int OP_WIDTH   = 32,
  parameter  int DEPTH      = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int RES_WIDTH  = 2 * OP_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  opcode_t                     opcode,
  input  logic signed [OP_WIDTH-1:0]  operand_a,
  input  logic signed [OP_WIDTH-1:0]  operand_b,
  input  logic [ADDR_WIDTH-1:0]       write_pointer,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       read_pointer,
`ifdef INSTR_REG_PARITY_EN
  input  logic                        par_inject,
  output logic                        rd_par_err,
`endif
  output logic                        rd_valid,
  output logic                        rd_hit,
  output opcode_t                     rd_opc,
  output logic signed [OP_WIDTH-1:0]  rd_op_a,
  output logic signed [OP_WIDTH-1:0]  rd_op_b,
  output logic signed [RES_WIDTH-1:0] rd_result,
  output logic [ADDR_WIDTH:0]         entry_count,
  output logic                        div0_err
);
  localparam int DATA_W = 3 + 2 * OP_WIDTH + RES_WIDTH;
  localparam int CNT_W  = $clog2(OP_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(OP_WIDTH - 1);

  typedef enum logic {S_IDLE, S_DIVIDE} state_t;
  state_t state_reg, state_next;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    valid_reg;
  logic [ADDR_WIDTH:0] count_reg;
  logic                div0_reg;

  opcode_t                    div_opc_reg;
  logic signed [OP_WIDTH-1:0] div_a_reg, div_b_reg;
  logic [ADDR_WIDTH-1:0]      div_ptr_reg;
  logic [OP_WIDTH-1:0]        quo_reg, rem_reg, dvs_reg;
  logic [CNT_W-1:0]           cnt_reg;

  logic                  rd_valid_reg, rd_hit_reg;
  logic [DATA_W-1:0]     rd_raw_reg;
  logic [DATA_W-1:0]     rd_data;

  logic signed [RES_WIDTH-1:0] a_ext, b_ext, alu_res, div_res;
  logic [OP_WIDTH-1:0]         abs_a, abs_b;
  logic                        is_divmod, b_zero;

  assign a_ext     = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
  assign b_ext     = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
  assign abs_a     = operand_a[OP_WIDTH-1] ? -operand_a : operand_a;
  assign abs_b     = operand_b[OP_WIDTH-1] ? -operand_b : operand_b;
  assign is_divmod = (opcode == DIV) || (opcode == MOD);
  assign b_zero    = (operand_b == '0);

  always_comb begin
    alu_res = '0;
    case (opcode)
      PASSA:   alu_res = a_ext;
      PASSB:   alu_res = b_ext;
      ADD:     alu_res = a_ext + b_ext;
      SUB:     alu_res = a_ext - b_ext;
      MULT:    alu_res = a_ext * b_ext;
      default: alu_res = '0;
    endcase
  end

  // One restoring step on magnitudes; the dividend shifts out of quo_reg as quotient bits shift in.
  logic [OP_WIDTH:0]   rem_shift, rem_sub;
  logic                step_ge;
  logic [OP_WIDTH-1:0] rem_step, quo_step, quo_fix, rem_fix;

  always_comb begin
    rem_shift = {rem_reg, quo_reg[OP_WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_reg};
    step_ge   = (rem_shift >= {1'b0, dvs_reg});
    rem_step  = step_ge ? rem_sub[OP_WIDTH-1:0] : rem_shift[OP_WIDTH-1:0];
    quo_step  = {quo_reg[OP_WIDTH-2:0], step_ge};
    quo_fix   = (div_a_reg[OP_WIDTH-1] ^ div_b_reg[OP_WIDTH-1]) ? -quo_step : quo_step;
    rem_fix   = div_a_reg[OP_WIDTH-1] ? -rem_step : rem_step;
    div_res   = (div_opc_reg == DIV) ? {{OP_WIDTH{quo_fix[OP_WIDTH-1]}}, quo_fix}
                                     : {{OP_WIDTH{rem_fix[OP_WIDTH-1]}}, rem_fix};
  end

  logic                        commit_en, div_start, div0_set;
  logic [ADDR_WIDTH-1:0]       commit_ptr;
  opcode_t                     commit_opc;
  logic signed [OP_WIDTH-1:0]  commit_a, commit_b;
  logic signed [RES_WIDTH-1:0] commit_res;
  logic [DATA_W-1:0]           commit_data;

  always_comb begin
    state_next = state_reg;
    commit_en  = 1'b0;
    div_start  = 1'b0;
    div0_set   = 1'b0;
    commit_ptr = write_pointer;
    commit_opc = opcode;
    commit_a   = operand_a;
    commit_b   = operand_b;
    commit_res = alu_res;
    case (state_reg)
      S_IDLE: begin
        if (wr_valid) begin
          if (is_divmod && !b_zero) begin
            div_start  = 1'b1;
            state_next = S_DIVIDE;
          end else begin
            commit_en = 1'b1;
            div0_set  = is_divmod;
          end
        end
      end
      S_DIVIDE: begin
        commit_ptr = div_ptr_reg;
        commit_opc = div_opc_reg;
        commit_a   = div_a_reg;
        commit_b   = div_b_reg;
        commit_res = div_res;
        if (cnt_reg == LAST_STEP) begin
          commit_en  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign commit_data = {commit_opc, commit_a, commit_b, commit_res};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      valid_reg   <= '0;
      count_reg   <= '0;
      div0_reg    <= 1'b0;
      div_opc_reg <= ZERO;
      div_a_reg   <= '0;
      div_b_reg   <= '0;
      div_ptr_reg <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (div0_set)
        div0_reg <= 1'b1;
      if (commit_en) begin
        valid_reg[commit_ptr] <= 1'b1;
        if (!valid_reg[commit_ptr])
          count_reg <= count_reg + (ADDR_WIDTH+1)'(1);
      end
      if (div_start) begin
        div_opc_reg <= opcode;
        div_a_reg   <= operand_a;
        div_b_reg   <= operand_b;
        div_ptr_reg <= write_pointer;
        quo_reg     <= abs_a;
        rem_reg     <= '0;
        dvs_reg     <= abs_b;
        cnt_reg     <= '0;
      end else if (state_reg == S_DIVIDE) begin
        quo_reg <= quo_step;
        rem_reg <= rem_step;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Storage carries no reset; unwritten entries are masked to zero through the valid bits.
  always_ff @(posedge clk) begin
    if (commit_en)
      mem[commit_ptr] <= commit_data;
    if (rd_en)
      rd_raw_reg <= mem[read_pointer];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_reg <= 1'b0;
      rd_hit_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en)
        rd_hit_reg <= valid_reg[read_pointer];
    end
  end

  assign rd_data     = rd_hit_reg ? rd_raw_reg : '0;
  assign rd_opc      = opcode_t'(rd_data[DATA_W-1 -: 3]);
  assign rd_op_a     = rd_data[DATA_W-4 -: OP_WIDTH];
  assign rd_op_b     = rd_data[RES_WIDTH+OP_WIDTH-1 -: OP_WIDTH];
  assign rd_result   = rd_data[RES_WIDTH-1:0];
  assign rd_valid    = rd_valid_reg;
  assign rd_hit      = rd_hit_reg;
  assign wr_ready    = (state_reg == S_IDLE);
  assign entry_count = count_reg;
  assign div0_err    = div0_reg;

`ifdef INSTR_REG_PARITY_EN
  logic par_mem [DEPTH];
  logic rd_par_raw_reg;

  always_ff @(posedge clk) begin
    if (commit_en)
      par_mem[commit_ptr] <= (^commit_data) ^ par_inject;
    if (rd_en)
      rd_par_raw_reg <= par_mem[read_pointer];
  end

  assign rd_par_err = rd_hit_reg && ((^rd_raw_reg) != rd_par_raw_reg);
`endif

endmodule

// File: tb/tb_instr_register_param.sv
// Randomised self-checking bench for instr_register_param against an array-based reference model.
// Parity checks are active when INSTR_REG_PARITY_EN is defined.
module tb_instr_register_param;
  import instr_register_pkg::*;

  localparam int D = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_valid = 1'b0;
  logic rd_en = 1'b0;
  opcode_t opcode = ZERO;
  logic signed [31:0] operand_a = '0, operand_b = '0;
  logic [4:0] write_pointer = '0, read_pointer = '0;
  logic wr_ready, rd_valid, rd_hit, div0_err;
  opcode_t rd_opc;
  logic signed [31:0] rd_op_a, rd_op_b;
  logic signed [63:0] rd_result;
  logic [5:0] entry_count;
`ifdef INSTR_REG_PARITY_EN
  logic par_inject = 1'b0;
  logic rd_par_err;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic               valid;
    opcode_t            opc;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic [63:0]        res;
    logic               inj;
  } entry_t;

  entry_t model [D];
  int     model_count;
  logic   model_div0;

  instr_register_param dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .rd_en(rd_en), .read_pointer(read_pointer),
`ifdef INSTR_REG_PARITY_EN
    .par_inject(par_inject), .rd_par_err(rd_par_err),
`endif
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_opc(rd_opc), .rd_op_a(rd_op_a),
    .rd_op_b(rd_op_b), .rd_result(rd_result), .entry_count(entry_count),
    .div0_err(div0_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(opcode_t op, logic signed [31:0] a, logic signed [31:0] b);
    longint la, lb, q;
    la = a;
    lb = b;
    case (op)
      PASSA: return la;
      PASSB: return lb;
      ADD:   return la + lb;
      SUB:   return la - lb;
      MULT:  return la * lb;
      DIV: begin
        if (lb == 0) return 64'd0;
        q = la / lb;
        return longint'(int'(q));  // 32-bit quotient wraps, then sign-extends
      end
      MOD: begin
        if (lb == 0) return 64'd0;
        return la % lb;
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < D; i++)
      model[i] = '{1'b0, ZERO, 32'sd0, 32'sd0, 64'd0, 1'b0};
    model_count = 0;
    model_div0  = 1'b0;
  endfunction

  function automatic void model_write(opcode_t op, logic signed [31:0] a, logic signed [31:0] b,
                                      logic [4:0] ptr, logic inj);
    if (!model[ptr].valid) model_count++;
    model[ptr] = '{1'b1, op, a, b, ref_result(op, a, b), inj};
    if ((op == DIV || op == MOD) && b == 0) model_div0 = 1'b1;
  endfunction

  task automatic check_read(string tag, entry_t e);
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check({tag, "_hit"}, 64'(rd_hit), 64'(e.valid));
    check({tag, "_opc"}, 64'(rd_opc), 64'(e.opc));
    check({tag, "_a"}, rd_op_a, e.a);
    check({tag, "_b"}, rd_op_b, e.b);
    check({tag, "_res"}, rd_result, e.res);
`ifdef INSTR_REG_PARITY_EN
    check({tag, "_par"}, 64'(rd_par_err), 64'(e.valid & e.inj));
`endif
  endtask

  // Called #1 after a rising edge; returns #1 after a later rising edge.
  task automatic do_read(logic [4:0] ptr);
    entry_t e;
    e = model[ptr];
    rd_en = 1'b1;
    read_pointer = ptr;
    @(posedge clk); #1;
    rd_en = 1'b0;
    $display("RD ptr=%0d hit=%0b opc=%s res=%0d", ptr, rd_hit, rd_opc.name(), rd_result);
    check_read("rd", e);
    @(posedge clk); #1;
    check("rd_idle", 64'(rd_valid), 64'd0);
    check("rd_hold", rd_result, e.res);
  endtask

  task automatic do_write(opcode_t op, logic signed [31:0] a, logic signed [31:0] b, logic [4:0] ptr,
                          logic inj, logic rd, logic [4:0] rptr);
    entry_t old_e;
    int busy;
    logic slow;
    slow  = (op == DIV || op == MOD) && (b != 0);
    old_e = model[rptr];
    check("wr_ready_pre", 64'(wr_ready), 64'd1);
    wr_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = ptr;
    rd_en = rd; read_pointer = rptr;
`ifdef INSTR_REG_PARITY_EN
    par_inject = inj;
`endif
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_en = 1'b0;
    if (rd) check_read("rd_same_edge", old_e);
    if (slow) begin
      busy = 0;
      while (wr_ready == 1'b0 && busy < 100) begin
        busy++;
        // Requests while busy must be dropped, not queued.
        wr_valid = 1'($urandom_range(0, 1));
        opcode = opcode_t'(3'($urandom_range(0, 7)));
        write_pointer = 5'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      check("busy_cycles", 64'(busy), 64'd32);
    end else begin
      check("wr_ready_stay", 64'(wr_ready), 64'd1);
    end
`ifdef INSTR_REG_PARITY_EN
    par_inject = 1'b0;
`endif
    model_write(op, a, b, ptr, inj);
    $display("WR op=%s ptr=%0d a=%0d b=%0d inj=%0b busy=%0b", op.name(), ptr, a, b, inj, slow);
    check("entry_count", 64'(entry_count), 64'(model_count));
    check("div0_err", 64'(div0_err), 64'(model_div0));
  endtask

  initial begin
    opcode_t op;
    logic signed [31:0] a, b;
    logic [4:0] ptr, rptr;
    logic inj, rd;

    model_reset();
    repeat (3) @(posedge clk); #1;
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_hit", 64'(rd_hit), 64'd0);
    check("rst_rd_result", rd_result, 64'd0);
    check("rst_count", 64'(entry_count), 64'd0);
    check("rst_div0", 64'(div0_err), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < D; i++) do_read(5'(i));

    do_write(ADD, 7, -3, 5'd5, 1'b0, 1'b0, 5'd0);
    do_read(5'd5);
    check("dir_add_res", rd_result, 64'd4);
    check("dir_add_opc", 64'(rd_opc), 64'(ADD));
    check("dir_add_cnt", 64'(entry_count), 64'd1);
    do_write(MULT, -4, 6, 5'd5, 1'b0, 1'b0, 5'd0);
    do_read(5'd5);
    check("dir_mult_res", rd_result, 64'(-24));
    check("dir_mult_cnt", 64'(entry_count), 64'd1);
    do_write(DIV, -7, 2, 5'd3, 1'b0, 1'b0, 5'd0);
    do_read(5'd3);
    check("dir_div_res", rd_result, 64'(-3));
    do_write(MOD, -7, 2, 5'd4, 1'b0, 1'b0, 5'd0);
    do_read(5'd4);
    check("dir_mod_res", rd_result, 64'(-1));
    do_write(DIV, 32'sh8000_0000, -1, 5'd6, 1'b0, 1'b0, 5'd0);
    do_read(5'd6);
    check("dir_divmin_res", rd_result, 64'hFFFF_FFFF_8000_0000);
    do_write(MOD, 32'sh8000_0000, -1, 5'd7, 1'b0, 1'b0, 5'd0);
    do_read(5'd7);
    check("dir_modmin_res", rd_result, 64'd0);
    do_write(DIV, 9, 0, 5'd8, 1'b0, 1'b0, 5'd0);
    do_read(5'd8);
    check("dir_div0_res", rd_result, 64'd0);
    check("dir_div0_flag", 64'(div0_err), 64'd1);
`ifdef INSTR_REG_PARITY_EN
    do_write(ADD, 1, 2, 5'd2, 1'b1, 1'b0, 5'd0);
    do_read(5'd2);
    check("dir_par_inj", 64'(rd_par_err), 64'd1);
    do_write(ADD, 1, 2, 5'd2, 1'b0, 1'b0, 5'd0);
    do_read(5'd2);
    check("dir_par_clean", 64'(rd_par_err), 64'd0);
`endif

    for (int t = 0; t < 120; t++) begin
      op = opcode_t'(3'($urandom_range(0, 7)));
      a = ($urandom_range(0, 7) == 0) ? 32'sh8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 0;
        1:       b = -1;
        2:       b = 32'($urandom_range(1, 9));
        default: b = 32'($urandom);
      endcase
      ptr  = 5'($urandom);
      rd   = 1'($urandom_range(0, 1));
      rptr = ($urandom_range(0, 1) == 1) ? ptr : 5'($urandom);
`ifdef INSTR_REG_PARITY_EN
      inj = 1'($urandom_range(0, 1));
`else
      inj = 1'b0;
`endif
      do_write(op, a, b, ptr, inj, rd, rptr);
    end
    for (int i = 0; i < D; i++) do_read(5'(i));

    // Reset asserted in the tenth DIVIDE cycle discards the division.
    wr_valid = 1'b1; opcode = DIV; operand_a = 100; operand_b = 7; write_pointer = 5'd9;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (9) @(posedge clk); #1;
    check("rstdiv_busy", 64'(wr_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    check("rstdiv_ready", 64'(wr_ready), 64'd1);
    check("rstdiv_count", 64'(entry_count), 64'd0);
    check("rstdiv_div0", 64'(div0_err), 64'd0);
    check("rstdiv_rd_valid", 64'(rd_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (40) @(posedge clk); #1;
    check("rstdiv_ready_late", 64'(wr_ready), 64'd1);
    check("rstdiv_count_late", 64'(entry_count), 64'd0);
    do_read(5'd9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_register_param.md
Name: instr_register_param

Overview:
- Parametrised next-generation instruction register: stores {opcode, operand_a, operand_b, result} per entry and computes the result on write.
- Generalised operand width and depth.
- Valid/ready write handshake; DIV/MOD executed by a multi-cycle iterative divider.
- Registered read port with entry-valid flag, occupancy counter and sticky divide-by-zero flag.
- Sits in the same slot as the existing instr_register; driven by the testbench/stimulus layer.

Parameters:
- OP_WIDTH, 32, signed operand width; result width RES_WIDTH = 2*OP_WIDTH.
- DEPTH, 32, number of entries (power of two, >= 2).
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- wr_valid  input  1  write request.
- wr_ready  output  1  block can accept a write this cycle.
- opcode  input  3  opcode_t from instr_register_pkg (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD).
- operand_a  input  OP_WIDTH  signed.
- operand_b  input  OP_WIDTH  signed.
- write_pointer  input  ADDR_WIDTH  target entry.
- rd_en  input  1  read request.
- read_pointer  input  ADDR_WIDTH  entry to read.
- rd_valid  output  1  read data valid (1 cycle after rd_en).
- rd_hit  output  1  entry read had been written since reset.
- rd_opc  output  3  stored opcode.
- rd_op_a  output  OP_WIDTH  stored operand_a.
- rd_op_b  output  OP_WIDTH  stored operand_b.
- rd_result  output  RES_WIDTH  stored result.
- entry_count  output  ADDR_WIDTH+1  number of valid entries.
- div0_err  output  1  sticky: a DIV/MOD with operand_b==0 was accepted.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All entries {ZERO,0,0,0}; all valid bits 0.
  - wr_ready=1, rd_valid=0, rd_hit=0, rd_* = 0, entry_count=0, div0_err=0.
  - FSM returns to IDLE. An in-flight division is discarded with no commit.
- Accept: wr_valid && wr_ready at a rising edge. Inputs are sampled at that edge only.
- FSM states: IDLE, DIVIDE.
  - IDLE, accept of non-DIV/MOD opcode: result computed combinationally, entry written at the same edge, stay in IDLE. Data is readable by an rd_en issued in the next cycle.
  - IDLE, accept of DIV/MOD with operand_b != 0: latch operands/pointer/opcode, go to DIVIDE, wr_ready=0.
  - DIVIDE: one quotient bit per cycle (restoring, on magnitudes) for exactly OP_WIDTH cycles. Entry committed on the edge ending the OP_WIDTH-th DIVIDE cycle, then return to IDLE; wr_ready=1 in the following cycle.
  - DIV/MOD with operand_b == 0: result 0, committed at the accept edge (no DIVIDE), div0_err set to 1.
- Arithmetic (signed, result sign-extended to RES_WIDTH):
  - ZERO: 0. PASSA: a. PASSB: b.
  - ADD: a+b. SUB: a-b. MULT: full 2*OP_WIDTH product.
  - DIV: truncates toward zero. MOD: remainder has the sign of the dividend.
  - Most-negative / -1: quotient is -(2^(OP_WIDTH-1)) sign-extended; remainder 0.
- Read:
  - rd_en at edge N gives rd_valid=1 and data during cycle N+1; rd_valid=0 otherwise.
  - rd_* hold their last value when rd_valid=0.
  - rd_hit = valid bit of the addressed entry.
  - Same-edge read and commit to the same address: read returns the old contents.
- entry_count: +1 on commit to an entry whose valid bit is 0; unchanged on overwrite. Saturates naturally at DEPTH.
- Pointers wrap naturally modulo DEPTH; no out-of-range address exists.
- wr_valid while wr_ready=0 is ignored (not queued); the source must hold the request.

Optional Feature:
- Macro: INSTR_REG_PARITY_EN.
- Defined:
  - Each entry stores an even-parity bit over {opc,op_a,op_b,result}, computed at commit.
  - Extra input par_inject (1): when high at the commit edge, the stored parity is inverted.
  - Extra output rd_par_err (1): valid with rd_valid; 1 when recomputed parity != stored parity; reset 0.
- Undefined: no parity storage, no par_inject/rd_par_err ports; behaviour otherwise identical.

Test Plan:
- Reset then read every entry -> rd_valid=1 one cycle after each rd_en, rd_hit=0, all fields 0, entry_count=0.
- Write ADD a=7 b=-3 to entry 5, read entry 5 next cycle -> rd_opc=ADD, rd_result=4, rd_hit=1, entry_count=1. Overwrite entry 5 with MULT a=-4 b=6 -> result -24, entry_count stays 1.
- Write DIV a=-7 b=2 to entry 3 -> wr_ready low exactly 32 cycles, then read gives -3. MOD a=-7 b=2 -> -1. wr_valid during busy is not accepted.
- DIV a=9 b=0 -> committed immediately with result 0, wr_ready stays 1, div0_err=1 and stays 1 after later valid writes until reset.
- Assert reset_n=0 at DIVIDE cycle 10 -> wr_ready=1 immediately, target entry unwritten (rd_hit=0), entry_count=0.
- With INSTR_REG_PARITY_EN: write with par_inject=1 to entry 2, read -> rd_par_err=1. Write without injection -> rd_par_err=0.
